// File: rtl/result_drain_sink.sv
// result_drain_sink
//   Consumer end of the accelerator output path. Reads one status word from the
//   status FIFO and, when that status is OK, one result word from the result
//   FIFO. The pair is then presented downstream on a valid/ready handshake.
//   Delivered pairs update the counters and the running checksum. A sticky
//   timeout flag records any OK status whose result did not arrive in time.
//
// Ports
//   clock, reset              rising-edge clock; asynchronous active-high reset
//   status_empty/data/r_en    status FIFO read side (data valid cycle after r_en)
//   result_empty/data/r_en    result FIFO read side (data valid cycle after r_en)
//   sink_ready                downstream accepts the presented pair
//   out_valid/result/status   presented pair
//   result_count/error_count  OK / non-OK pairs delivered (wrap)
//   checksum                  running sum of delivered out_result (wrap)
//   timeout                   sticky result-wait timeout flag
module result_drain_sink #(
    parameter int unsigned RESULT_WIDTH   = 32,
    parameter int unsigned STATUS_WIDTH   = 4,
    parameter int unsigned STATUS_OK      = 0,
    parameter int unsigned COUNT_WIDTH    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    status_empty,
    input  logic [STATUS_WIDTH-1:0] status_data,
    output logic                    status_r_en,
    input  logic                    result_empty,
    input  logic [RESULT_WIDTH-1:0] result_data,
    output logic                    result_r_en,
    input  logic                    sink_ready,
    output logic                    out_valid,
    output logic [RESULT_WIDTH-1:0] out_result,
    output logic [STATUS_WIDTH-1:0] out_status,
    output logic [COUNT_WIDTH-1:0]  result_count,
    output logic [COUNT_WIDTH-1:0]  error_count,
    output logic [RESULT_WIDTH-1:0] checksum,
    output logic                    timeout
);

    localparam int unsigned WAIT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StSWait,
        StRReq,
        StRWait,
        StPresent
    } state_e;

    state_e                  state_q, state_d;
    logic [RESULT_WIDTH-1:0] out_result_q, out_result_d;
    logic [STATUS_WIDTH-1:0] out_status_q, out_status_d;
    logic [WAIT_WIDTH-1:0]   wait_q, wait_d;
    logic                    pair_to_q, pair_to_d;  // current pair ended by timeout
    logic                    timeout_q, timeout_d;
    logic [COUNT_WIDTH-1:0]  result_count_q, result_count_d;
    logic [COUNT_WIDTH-1:0]  error_count_q, error_count_d;
    logic [RESULT_WIDTH-1:0] checksum_q, checksum_d;
    logic                    status_rd, result_rd;

    always_comb begin
        state_d        = state_q;
        out_result_d   = out_result_q;
        out_status_d   = out_status_q;
        wait_d         = wait_q;
        pair_to_d      = pair_to_q;
        timeout_d      = timeout_q;
        result_count_d = result_count_q;
        error_count_d  = error_count_q;
        checksum_d     = checksum_q;
        status_rd      = 1'b0;
        result_rd      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!status_empty) begin
                    status_rd = 1'b1;
                    state_d   = StSWait;
                end
            end
            StSWait: begin
                out_status_d = status_data;
                pair_to_d    = 1'b0;
                if (status_data == STATUS_WIDTH'(STATUS_OK)) begin
                    wait_d  = '0;
                    state_d = StRReq;
                end else begin
                    out_result_d = '0;
                    state_d      = StPresent;
                end
            end
            StRReq: begin
                if (!result_empty) begin
                    result_rd = 1'b1;
                    state_d   = StRWait;
                end else begin
                    wait_d = wait_q + 1'b1;
                    // The increment made this cycle brings the count to TIMEOUT_CYCLES.
                    if (wait_q == WAIT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        timeout_d    = 1'b1;
                        pair_to_d    = 1'b1;
                        out_result_d = '0;
                        state_d      = StPresent;
                    end
                end
            end
            StRWait: begin
                out_result_d = result_data;
                state_d      = StPresent;
            end
            StPresent: begin
                if (sink_ready) begin
                    checksum_d = checksum_q + out_result_q;
                    if (out_status_q == STATUS_WIDTH'(STATUS_OK) && !pair_to_q) begin
                        result_count_d = result_count_q + 1'b1;
                    end else begin
                        error_count_d = error_count_q + 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            out_result_q   <= '0;
            out_status_q   <= '0;
            wait_q         <= '0;
            pair_to_q      <= 1'b0;
            timeout_q      <= 1'b0;
            result_count_q <= '0;
            error_count_q  <= '0;
            checksum_q     <= '0;
        end else begin
            state_q        <= state_d;
            out_result_q   <= out_result_d;
            out_status_q   <= out_status_d;
            wait_q         <= wait_d;
            pair_to_q      <= pair_to_d;
            timeout_q      <= timeout_d;
            result_count_q <= result_count_d;
            error_count_q  <= error_count_d;
            checksum_q     <= checksum_d;
        end
    end

    // Read enables are decoded from state; masking with reset keeps them low
    // while reset is held even if a FIFO reports data.
    assign status_r_en  = status_rd & ~reset;
    assign result_r_en  = result_rd & ~reset;
    assign out_valid    = (state_q == StPresent);
    assign out_result   = out_result_q;
    assign out_status   = out_status_q;
    assign result_count = result_count_q;
    assign error_count  = error_count_q;
    assign checksum     = checksum_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_result_drain_sink.sv
module tb_result_drain_sink;

    localparam int RW = 32;
    localparam int SW = 4;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          status_empty = 1'b1;
    logic [SW-1:0] status_data = '0;
    logic          status_r_en;
    logic          result_empty = 1'b1;
    logic [RW-1:0] result_data = '0;
    logic          result_r_en;
    logic          sink_ready = 1'b0;
    logic          out_valid;
    logic [RW-1:0] out_result;
    logic [SW-1:0] out_status;
    logic [CW-1:0] result_count;
    logic [CW-1:0] error_count;
    logic [RW-1:0] checksum;
    logic          timeout;

    result_drain_sink #(
        .RESULT_WIDTH  (RW),
        .STATUS_WIDTH  (SW),
        .STATUS_OK     (0),
        .COUNT_WIDTH   (CW),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .status_empty(status_empty),
        .status_data (status_data),
        .status_r_en (status_r_en),
        .result_empty(result_empty),
        .result_data (result_data),
        .result_r_en (result_r_en),
        .sink_ready  (sink_ready),
        .out_valid   (out_valid),
        .out_result  (out_result),
        .out_status  (out_status),
        .result_count(result_count),
        .error_count (error_count),
        .checksum    (checksum),
        .timeout     (timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [RW-1:0] res;
        logic [SW-1:0] st;
        int            lat;
    } exp_t;

    exp_t          exp_q[$];
    logic [SW-1:0] sq[$];
    logic [RW-1:0] rq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rcyc = 0;
    int s_pulses = 0;
    int r_pulses = 0;
    int both_pulses = 0;
    bit prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clock) cyc++;

    // FIFO models: registered read data, empty flag updated at the clock edge.
    always @(posedge clock) begin
        if (status_r_en && sq.size() > 0) status_data <= sq.pop_front();
        if (result_r_en && rq.size() > 0) result_data <= rq.pop_front();
        status_empty <= (sq.size() == 0);
        result_empty <= (rq.size() == 0);
    end

    // Monitor: inputs change 2 units after posedge, so negedge sees stable values.
    always @(negedge clock) begin
        if (!reset) begin
            if (status_r_en) begin
                s_pulses++;
                rcyc = cyc;
            end
            if (result_r_en) r_pulses++;
            if (status_r_en && result_r_en) both_pulses++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pair: got result 0x%0h status %0d expected none",
                             out_result, out_status);
                end else begin
                    if (!prev_valid) chk("latency", cyc - rcyc, exp_q[0].lat);
                    chk("out_result", out_result, exp_q[0].res);
                    chk("out_status", 32'(out_status), 32'(exp_q[0].st));
                    if (sink_ready) exp_q.delete(0);
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sq.delete();
        rq.delete();
        exp_q.delete();
        tick(3);
        reset       = 1'b0;
        s_pulses    = 0;
        r_pulses    = 0;
        both_pulses = 0;
        prev_valid  = 1'b0;
        tick(1);
    endtask

    task automatic push_exp(input logic [RW-1:0] res, input logic [SW-1:0] st, input int lat);
        exp_t e;
        e.res = res;
        e.st  = st;
        e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pairs pending expected 0", exp_q.size());
            exp_q.delete();
        end
        tick(2);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_result"}, out_result, 0);
        chk({tag, "_out_status"}, 32'(out_status), 0);
        chk({tag, "_result_count"}, 32'(result_count), 0);
        chk({tag, "_error_count"}, 32'(error_count), 0);
        chk({tag, "_checksum"}, checksum, 0);
        chk({tag, "_timeout"}, 32'(timeout), 0);
        chk({tag, "_status_r_en"}, 32'(status_r_en), 0);
        chk({tag, "_result_r_en"}, 32'(result_r_en), 0);
    endtask

    initial begin
        int n;

        // Power-on reset state
        tick(3);
        chk_all_zero("por");
        reset = 1'b0;
        tick(1);

        // Reset asserted while waiting on result FIFO read data
        sink_ready = 1'b1;
        sq.push_back(4'd0);
        rq.push_back(32'h1234_5678);
        n = 0;
        while (!result_r_en && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("reset_test_result_r_en_seen", 32'(result_r_en), 1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        sq.delete();
        rq.delete();
        tick(2);
        reset = 1'b0;
        prev_valid = 1'b0;
        tick(10);
        chk("after_reset_result_count", 32'(result_count), 0);
        chk("after_reset_out_valid", 32'(out_valid), 0);

        // Single OK pair
        do_reset();
        sink_ready = 1'b1;
        push_exp(32'h0000_002A, 4'd0, 4);
        sq.push_back(4'd0);
        rq.push_back(32'h0000_002A);
        wait_drain(30);
        chk("ok_result_count", 32'(result_count), 1);
        chk("ok_error_count", 32'(error_count), 0);
        chk("ok_checksum", checksum, 32'h2A);
        chk("ok_status_pulses", s_pulses, 1);
        chk("ok_result_pulses", r_pulses, 1);

        // Error status, result FIFO empty
        do_reset();
        push_exp(32'h0, 4'd3, 2);
        sq.push_back(4'd3);
        wait_drain(30);
        chk("err_error_count", 32'(error_count), 1);
        chk("err_result_count", 32'(result_count), 0);
        chk("err_result_pulses", r_pulses, 0);
        chk("err_timeout", 32'(timeout), 0);
        chk("err_checksum", checksum, 0);

        // Backpressure
        do_reset();
        sink_ready = 1'b0;
        push_exp(32'h0000_0010, 4'd0, 4);
        sq.push_back(4'd0);
        rq.push_back(32'h0000_0010);
        n = 0;
        while (!out_valid && n < 20) begin
            tick(1);
            n++;
        end
        chk("bp_valid_seen", 32'(out_valid), 1);
        tick(5);
        chk("bp_valid_held", 32'(out_valid), 1);
        chk("bp_result_count_held", 32'(result_count), 0);
        chk("bp_error_count_held", 32'(error_count), 0);
        chk("bp_checksum_held", checksum, 0);
        chk("bp_status_pulses", s_pulses, 1);
        chk("bp_result_pulses", r_pulses, 1);
        sink_ready = 1'b1;
        wait_drain(10);
        chk("bp_result_count", 32'(result_count), 1);
        chk("bp_checksum", checksum, 32'h10);

        // Timeout: OK status with no result ever arriving
        do_reset();
        sink_ready = 1'b1;
        push_exp(32'h0, 4'd0, 66);
        sq.push_back(4'd0);
        wait_drain(150);
        chk("to_timeout", 32'(timeout), 1);
        chk("to_error_count", 32'(error_count), 1);
        chk("to_result_count", 32'(result_count), 0);
        chk("to_result_pulses", r_pulses, 0);
        tick(5);
        chk("to_timeout_sticky", 32'(timeout), 1);

        // Stream with checksum wrap
        do_reset();
        sink_ready = 1'b1;
        push_exp(32'hFFFF_FFFF, 4'd0, 4);
        push_exp(32'h0000_0002, 4'd0, 4);
        push_exp(32'h0000_0000, 4'd5, 2);
        push_exp(32'h0000_0007, 4'd0, 4);
        sq.push_back(4'd0);
        sq.push_back(4'd0);
        sq.push_back(4'd5);
        sq.push_back(4'd0);
        rq.push_back(32'hFFFF_FFFF);
        rq.push_back(32'h0000_0002);
        rq.push_back(32'h0000_0007);
        wait_drain(100);
        chk("stream_checksum", checksum, 32'h0000_0008);
        chk("stream_result_count", 32'(result_count), 3);
        chk("stream_error_count", 32'(error_count), 1);
        chk("stream_timeout", 32'(timeout), 0);
        chk("stream_status_pulses", s_pulses, 4);
        chk("stream_result_pulses", r_pulses, 3);
        chk("stream_no_overlap_r_en", both_pulses, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
